// File: rtl/mul_unit_pipe.sv
// mul_unit_pipe: pipelined integer multiplier (MUL, MULH, MULHSU, MULHU, MULW).
//
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   kill_i               flush all in-flight ops and drop the presented op
//   stall_i              freeze the whole pipeline, including the output register
//   valid_i / ready_o    issue handshake (ready_o is combinational)
//   op_i, op_32_i        operation select and word-op flag
//   src1_i, src2_i       operands
//   tag_i                opaque tag carried alongside the op
//   valid_o, result_o,   registered result and its tag
//   tag_o
//
// Full-width ops spend STAGES-1 cycles in the stage registers and then load
// the output register; word ops load the output register one stage earlier.
// For STAGES=2 a word op goes from the issue inputs straight to the output.

`timescale 1ns/1ps

module mul_unit_pipe #(
    parameter int XLEN   = 64,
    parameter int STAGES = 3,
    parameter int TAG_W  = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             kill_i,
    input  logic             stall_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic             op_32_i,
    input  logic [XLEN-1:0]  src1_i,
    input  logic [XLEN-1:0]  src2_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int                WORD_ST = STAGES - 2;
    localparam int                FULL_ST = STAGES - 1;
    localparam logic [XLEN-1:0]   ONE_X   = XLEN'(1);
    localparam logic [2*XLEN-1:0] ONE_2X  = (2*XLEN)'(1);

    typedef struct packed {
        logic [2:0]       op;
        logic             word;
        logic             neg;
        logic [XLEN-1:0]  mag1;
        logic [XLEN-1:0]  mag2;
        logic [TAG_W-1:0] tag;
    } stage_t;

    stage_t issue;
    logic   accept;
    logic   hazard;

    stage_t st_q  [1:STAGES-1];
    logic   vld_q [1:STAGES-1];
    logic   adv   [1:STAGES-1];

    // Index 0 is the issue side (combinational), 1.. are the stage registers.
    stage_t cur   [0:STAGES-1];
    logic   cur_v [0:STAGES-1];

    logic s1_signed, s2_signed, sgn1, sgn2, is_word;
    logic [31:0] lo1, lo2;

    always_comb begin
        s1_signed = (op_i == 3'b000) || (op_i == 3'b001) || (op_i == 3'b010);
        s2_signed = (op_i == 3'b000) || (op_i == 3'b001);
        is_word   = op_32_i && (op_i == 3'b000) && (XLEN == 64);
        sgn1      = s1_signed && (is_word ? src1_i[31] : src1_i[XLEN-1]);
        sgn2      = s2_signed && (is_word ? src2_i[31] : src2_i[XLEN-1]);
        lo1       = sgn1 ? (~src1_i[31:0] + 32'd1) : src1_i[31:0];
        lo2       = sgn2 ? (~src2_i[31:0] + 32'd1) : src2_i[31:0];
        issue.op   = op_i;
        issue.word = is_word;
        issue.neg  = sgn1 ^ sgn2;
        issue.mag1 = is_word ? XLEN'(lo1) : (sgn1 ? (~src1_i + ONE_X) : src1_i);
        issue.mag2 = is_word ? XLEN'(lo2) : (sgn2 ? (~src2_i + ONE_X) : src2_i);
        issue.tag  = tag_i;
    end

    // A word op issued right behind a full op would reach the output on the
    // same edge as that full op.
    assign hazard  = op_32_i && (op_i == 3'b000) && vld_q[1] && !st_q[1].word;
    assign ready_o = !stall_i && !hazard;
    assign accept  = valid_i && ready_o;

    always_comb begin
        cur[0]   = issue;
        cur_v[0] = accept;
        for (int s = 1; s < STAGES; s++) begin
            cur[s]   = st_q[s];
            cur_v[s] = vld_q[s];
        end
        // Word ops leave before the last stage register and never enter it.
        for (int s = 1; s < STAGES; s++) begin
            adv[s] = cur_v[s-1] && !((s == FULL_ST) && cur[s-1].word);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int s = 1; s < STAGES; s++) begin
                vld_q[s] <= 1'b0;
                st_q[s]  <= '0;
            end
        end else if (kill_i) begin
            for (int s = 1; s < STAGES; s++) begin
                vld_q[s] <= 1'b0;
            end
        end else if (!stall_i) begin
            for (int s = 1; s < STAGES; s++) begin
                vld_q[s] <= adv[s];
                if (adv[s]) begin
                    st_q[s] <= cur[s-1];
                end
            end
        end
    end

    stage_t            wsrc, fsrc;
    logic [31:0]       wmag, wlo;
    logic [XLEN-1:0]   word_res, full_res;
    logic [2*XLEN-1:0] prod, sprod;
    logic              word_v, full_v;

    assign wsrc = cur[WORD_ST];
    assign fsrc = cur[FULL_ST];

    // Only the low 32 bits of the word product are ever needed.
    assign wmag     = wsrc.mag1[31:0] * wsrc.mag2[31:0];
    assign wlo      = wsrc.neg ? (~wmag + 32'd1) : wmag;
    assign word_res = XLEN'($signed(wlo));

    generate
        if (XLEN == 64) begin : g_pp64
            logic [XLEN+31:0] pp_lo, pp_hi;
            assign pp_lo = (XLEN+32)'(fsrc.mag1) * (XLEN+32)'(fsrc.mag2[31:0]);
            assign pp_hi = (XLEN+32)'(fsrc.mag1) * (XLEN+32)'(fsrc.mag2[XLEN-1:32]);
            assign prod  = {32'b0, pp_lo} + {pp_hi, 32'b0};
        end else begin : g_pp32
            assign prod = (2*XLEN)'(fsrc.mag1) * (2*XLEN)'(fsrc.mag2);
        end
    endgenerate

    assign sprod    = fsrc.neg ? (~prod + ONE_2X) : prod;
    assign full_res = fsrc.op[2] ? '0 :
                      (fsrc.op == 3'b000) ? sprod[XLEN-1:0] : sprod[2*XLEN-1:XLEN];

    assign word_v = cur_v[WORD_ST] && cur[WORD_ST].word;
    assign full_v = cur_v[FULL_ST];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_o  <= 1'b0;
            result_o <= '0;
            tag_o    <= '0;
        end else if (kill_i) begin
            valid_o <= 1'b0;
        end else if (!stall_i) begin
            valid_o <= word_v || full_v;
            if (word_v) begin
                result_o <= word_res;
                tag_o    <= wsrc.tag;
            end else if (full_v) begin
                result_o <= full_res;
                tag_o    <= fsrc.tag;
            end
        end
    end

endmodule
